// File: rtl/csr_mtrap_unit.sv
// ----------------------------------------------------------------------------
// csr_mtrap_unit
//
// Machine-mode CSR file and trap sequencer. Holds the M-mode status, trap
// and counter registers, serves the execute stage's CSR read/modify/write
// port, and turns exceptions, interrupts and mret into a registered
// one-cycle PC redirect for fetch.
//
// Parameters
//   XLEN         register width, 32 or 64
//   NUM_LCL_IRQ  local interrupt lines at mip/mie bits 16.. (<=16 for XLEN=32)
//   HART_ID      value returned by mhartid
//   MISA_EXT     misa extension bits; mxl comes from XLEN
//
// Ports
//   clk, rst                        clock, async active-high reset
//   csr_valid/op/wr_en/addr/wdata   CSR access from execute
//   csr_rdata, csr_illegal          old value and illegal flag (combinational)
//   exc_valid/cause/pc/tval         synchronous exception
//   irq_take, irq_pc                core accepts the pending interrupt
//   mret_valid                      mret retiring
//   instret                         one instruction retired this cycle
//   meip, mtip, msip, lcl_irq       interrupt levels (registered into mip)
//   irq_pending                     interrupt request to decode
//   redirect_valid, redirect_pc     one-cycle registered redirect to fetch
// ----------------------------------------------------------------------------
module csr_mtrap_unit #(
    parameter int          XLEN        = 32,
    parameter int          NUM_LCL_IRQ = 16,
    parameter int          HART_ID     = 0,
    parameter logic [25:0] MISA_EXT    = 26'h100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   csr_valid,
    input  logic [1:0]             csr_op,
    input  logic                   csr_wr_en,
    input  logic [11:0]            csr_addr,
    input  logic [XLEN-1:0]        csr_wdata,
    output logic [XLEN-1:0]        csr_rdata,
    output logic                   csr_illegal,
    input  logic                   exc_valid,
    input  logic [4:0]             exc_cause,
    input  logic [XLEN-1:0]        exc_pc,
    input  logic [XLEN-1:0]        exc_tval,
    input  logic                   irq_take,
    input  logic [XLEN-1:0]        irq_pc,
    input  logic                   mret_valid,
    input  logic                   instret,
    input  logic                   meip,
    input  logic                   mtip,
    input  logic                   msip,
    input  logic [NUM_LCL_IRQ-1:0] lcl_irq,
    output logic                   irq_pending,
    output logic                   redirect_valid,
    output logic [XLEN-1:0]        redirect_pc
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [1:0] MXL = (XLEN == 32) ? 2'd1 : 2'd2;
    localparam logic [XLEN-1:0] MISA_VAL = {MXL, {(XLEN-28){1'b0}}, MISA_EXT};

    // Writable / implemented bits of mie and mip: MSI, MTI, MEI and locals.
    function automatic logic [XLEN-1:0] irq_mask_f();
        logic [XLEN-1:0] m;
        m     = '0;
        m[3]  = 1'b1;
        m[7]  = 1'b1;
        m[11] = 1'b1;
        for (int i = 0; i < NUM_LCL_IRQ; i++) m[16+i] = 1'b1;
        return m;
    endfunction
    localparam logic [XLEN-1:0] IRQ_MASK = irq_mask_f();

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            st_mie_q,   st_mie_d;
    logic            st_mpie_q,  st_mpie_d;
    logic [XLEN-1:0] mie_q,      mie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;
    logic [XLEN-1:0] mtval_q,    mtval_d;
    logic [XLEN-1:0] mip_q,      mip_d;
    logic [63:0]     mcycle_q,   mcycle_d;
    logic [63:0]     minstret_q, minstret_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q,    redirect_pc_d;

    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] pend;
    logic [4:0]      irq_code;
    logic            csr_hit;
    logic            csr_we;
    logic            irq_fire;
    logic [XLEN-1:0] wval;
    logic [XLEN-1:0] tvec_base;

    // ------------------------------------------------------------------
    // Read side and legality
    // ------------------------------------------------------------------
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = st_mpie_q;
        mstatus_rd[3]     = st_mie_q;
    end

    always_comb begin
        csr_rdata = '0;
        csr_hit   = 1'b1;
        case (csr_addr)
            A_MSTATUS:   csr_rdata = mstatus_rd;
            A_MISA:      csr_rdata = MISA_VAL;
            A_MIE:       csr_rdata = mie_q;
            A_MTVEC:     csr_rdata = mtvec_q;
            A_MSCRATCH:  csr_rdata = mscratch_q;
            A_MEPC:      csr_rdata = mepc_q;
            A_MCAUSE:    csr_rdata = mcause_q;
            A_MTVAL:     csr_rdata = mtval_q;
            A_MIP:       csr_rdata = mip_q;
            A_MCYCLE:    csr_rdata = mcycle_q[XLEN-1:0];
            A_MINSTRET:  csr_rdata = minstret_q[XLEN-1:0];
            A_MCYCLEH: begin
                if (XLEN == 32) csr_rdata = XLEN'(mcycle_q[63:32]);
                else            csr_hit   = 1'b0;
            end
            A_MINSTRETH: begin
                if (XLEN == 32) csr_rdata = XLEN'(minstret_q[63:32]);
                else            csr_hit   = 1'b0;
            end
            A_MVENDORID, A_MARCHID, A_MIMPID: csr_rdata = '0;
            A_MHARTID:   csr_rdata = XLEN'(HART_ID);
            default:     csr_hit   = 1'b0;
        endcase
    end

    // Read-only space (addr[11:10]=11) plus misa/mip reject writes.
    assign csr_illegal = csr_valid &
                         (!csr_hit || csr_op == 2'b00 ||
                          (csr_wr_en && (csr_addr[11:10] == 2'b11 ||
                                         csr_addr == A_MISA ||
                                         csr_addr == A_MIP)));

    assign csr_we = csr_valid & csr_wr_en & !csr_illegal;

    always_comb begin
        case (csr_op)
            2'b10:   wval = csr_rdata | csr_wdata;
            2'b11:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_wdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Interrupt selection
    // ------------------------------------------------------------------
    assign pend        = mip_q & mie_q;
    assign irq_pending = st_mie_q & (|pend);
    assign irq_fire    = irq_take & irq_pending;

    // Later assignments win: locals scanned high-to-low so the lowest index
    // wins among them, then MTI, MSI, MEI override in rising priority.
    always_comb begin
        irq_code = 5'd0;
        for (int i = NUM_LCL_IRQ - 1; i >= 0; i--) begin
            if (pend[16+i]) irq_code = 5'(16 + i);
        end
        if (pend[7])  irq_code = 5'd7;
        if (pend[3])  irq_code = 5'd3;
        if (pend[11]) irq_code = 5'd11;
    end

    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        st_mie_d         = st_mie_q;
        st_mpie_d        = st_mpie_q;
        mie_d            = mie_q;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        mcycle_d         = mcycle_q + 64'd1;
        minstret_d       = minstret_q + {63'd0, instret};
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        mip_d     = '0;
        mip_d[3]  = msip;
        mip_d[7]  = mtip;
        mip_d[11] = meip;
        for (int i = 0; i < NUM_LCL_IRQ; i++) mip_d[16+i] = lcl_irq[i];

        if (exc_valid) begin
            mepc_d           = exc_pc;
            mepc_d[1:0]      = 2'b00;
            mcause_d         = XLEN'(exc_cause);
            mtval_d          = exc_tval;
            st_mpie_d        = st_mie_q;
            st_mie_d         = 1'b0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = tvec_base;
        end else if (irq_fire) begin
            mepc_d              = irq_pc;
            mepc_d[1:0]         = 2'b00;
            mcause_d            = XLEN'(irq_code);
            mcause_d[XLEN-1]    = 1'b1;
            mtval_d             = '0;
            st_mpie_d           = st_mie_q;
            st_mie_d            = 1'b0;
            redirect_valid_d    = 1'b1;
            redirect_pc_d       = mtvec_q[0] ? tvec_base + XLEN'({irq_code, 2'b00})
                                             : tvec_base;
        end else if (mret_valid) begin
            st_mie_d         = st_mpie_q;
            st_mpie_d        = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mepc_q;
        end else if (csr_we) begin
            case (csr_addr)
                A_MSTATUS: begin
                    st_mie_d  = wval[3];
                    st_mpie_d = wval[7];
                end
                A_MIE:      mie_d = wval & IRQ_MASK;
                A_MTVEC: begin
                    mtvec_d    = wval;
                    mtvec_d[1] = 1'b0;
                end
                A_MSCRATCH: mscratch_d = wval;
                A_MEPC: begin
                    mepc_d      = wval;
                    mepc_d[1:0] = 2'b00;
                end
                A_MCAUSE:   mcause_d = wval;
                A_MTVAL:    mtval_d  = wval;
                // A write to either half replaces this cycle's increment.
                A_MCYCLE: begin
                    if (XLEN == 32) mcycle_d = {mcycle_q[63:32], wval[31:0]};
                    else            mcycle_d = 64'(wval);
                end
                A_MINSTRET: begin
                    if (XLEN == 32) minstret_d = {minstret_q[63:32], wval[31:0]};
                    else            minstret_d = 64'(wval);
                end
                A_MCYCLEH:   mcycle_d   = {wval[31:0], mcycle_q[31:0]};
                A_MINSTRETH: minstret_d = {wval[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie_q         <= 1'b0;
            st_mpie_q        <= 1'b0;
            mie_q            <= '0;
            mtvec_q          <= '0;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            mip_q            <= '0;
            mcycle_q         <= '0;
            minstret_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            st_mie_q         <= st_mie_d;
            st_mpie_q        <= st_mpie_d;
            mie_q            <= mie_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            mip_q            <= mip_d;
            mcycle_q         <= mcycle_d;
            minstret_q       <= minstret_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_mtrap_unit.sv
// ----------------------------------------------------------------------------
// tb_csr_mtrap_unit
//
// Directed bench for csr_mtrap_unit (XLEN=32, 16 local IRQs, HART_ID=5).
// A table of CSR accesses with hand-computed read data / illegal flags is
// applied one per cycle, followed by hand-written trap, mret, counter,
// interrupt-priority and async-reset sequences.
// ----------------------------------------------------------------------------
module tb_csr_mtrap_unit;

    localparam int XLEN = 32;
    localparam int NL   = 16;

    logic            clk, rst;
    logic            csr_valid, csr_wr_en;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata, csr_rdata;
    logic            csr_illegal;
    logic            exc_valid;
    logic [4:0]      exc_cause;
    logic [XLEN-1:0] exc_pc, exc_tval;
    logic            irq_take;
    logic [XLEN-1:0] irq_pc;
    logic            mret_valid, instret;
    logic            meip, mtip, msip;
    logic [NL-1:0]   lcl_irq;
    logic            irq_pending;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    csr_mtrap_unit #(.XLEN(XLEN), .NUM_LCL_IRQ(NL), .HART_ID(5), .MISA_EXT(26'h100)) dut (
        .clk(clk), .rst(rst),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_wr_en(csr_wr_en),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .irq_take(irq_take), .irq_pc(irq_pc), .mret_valid(mret_valid), .instret(instret),
        .meip(meip), .mtip(mtip), .msip(msip), .lcl_irq(lcl_irq),
        .irq_pending(irq_pending),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        ill;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_bad = 0;

    localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

    task automatic add(input logic [1:0] op, input logic we, input logic [11:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic ill);
        vec_t v;
        v.op = op; v.we = we; v.addr = a; v.wdata = wd; v.rdata = rd; v.ill = ill;
        tbl.push_back(v);
    endtask

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-cycle read through the CSR port (costs 1 time unit).
    task automatic chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        csr_valid = 1'b1; csr_op = RS; csr_wr_en = 1'b0; csr_addr = a;
        #1;
        cmp(nm, {31'd0, csr_illegal, csr_rdata}, {32'd0, exp});
        csr_valid = 1'b0;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_valid = 1'b1; csr_op = op; csr_wr_en = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_valid = 1'b0; csr_wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        csr_valid = 0; csr_op = 0; csr_wr_en = 0; csr_addr = 0; csr_wdata = 0;
        exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
        irq_take = 0; irq_pc = 0; mret_valid = 0; instret = 0;
        meip = 0; mtip = 0; msip = 0; lcl_irq = '0;

        // ---------------- reset state ----------------
        #3;
        cmp("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
        cmp("rst_redirect_pc", {32'd0, redirect_pc}, 64'd0);
        cmp("rst_irq_pending", {63'd0, irq_pending}, 64'd0);
        #9 rst = 1'b0;                       // t=12, next edge at 15
        chk("mcycle_first", 12'hB00, 32'h0);
        tick(); tick(); tick();
        chk("mcycle_after3", 12'hB00, 32'h3);

        // ---------------- table ----------------
        add(RS, 0, 12'h300, 0, 32'h0000_1800, 0);
        add(RS, 0, 12'h301, 0, 32'h4000_0100, 0);
        add(RS, 0, 12'h304, 0, 0, 0);
        add(RS, 0, 12'h305, 0, 0, 0);
        add(RS, 0, 12'h340, 0, 0, 0);
        add(RS, 0, 12'h341, 0, 0, 0);
        add(RS, 0, 12'h342, 0, 0, 0);
        add(RS, 0, 12'h343, 0, 0, 0);
        add(RS, 0, 12'h344, 0, 0, 0);
        add(RS, 0, 12'hB02, 0, 0, 0);
        add(RS, 0, 12'hB82, 0, 0, 0);
        add(RS, 0, 12'hF11, 0, 0, 0);
        add(RS, 0, 12'hF12, 0, 0, 0);
        add(RS, 0, 12'hF13, 0, 0, 0);
        add(RS, 0, 12'hF14, 0, 5, 0);
        add(RW, 1, 12'hF14, 1, 5, 1);
        add(RW, 1, 12'h7C0, 1, 0, 1);
        add(RS, 0, 12'h7C0, 0, 0, 1);
        add(2'b00, 1, 12'h340, 32'hFFFF, 0, 1);
        add(RW, 1, 12'h301, 0, 32'h4000_0100, 1);
        add(RS, 1, 12'h344, 8, 0, 1);
        add(RS, 0, 12'h344, 0, 0, 0);
        add(RS, 0, 12'hF14, 0, 5, 0);
        add(RS, 0, 12'h340, 0, 0, 0);
        add(RW, 1, 12'h340, 32'hA5A5_0F0F, 0, 0);
        add(RS, 0, 12'h340, 0, 32'hA5A5_0F0F, 0);
        add(RS, 1, 12'h340, 32'h0000_F000, 32'hA5A5_0F0F, 0);
        add(RC, 1, 12'h340, 32'hA500_0000, 32'hA5A5_FF0F, 0);
        add(RS, 0, 12'h340, 0, 32'h00A5_FF0F, 0);
        add(RW, 1, 12'h304, 32'hFFFF_FFFF, 0, 0);
        add(RS, 0, 12'h304, 0, 32'hFFFF_0888, 0);
        add(RW, 1, 12'h304, 0, 32'hFFFF_0888, 0);
        add(RS, 0, 12'h304, 0, 0, 0);
        add(RW, 1, 12'h305, 32'hFFFF_FFFF, 0, 0);
        add(RS, 0, 12'h305, 0, 32'hFFFF_FFFD, 0);
        add(RW, 1, 12'h305, 0, 32'hFFFF_FFFD, 0);
        add(RW, 1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 0);
        add(RS, 0, 12'h300, 0, 32'h0000_1888, 0);
        add(RC, 1, 12'h300, 32'h0000_0088, 32'h0000_1888, 0);
        add(RS, 0, 12'h300, 0, 32'h0000_1800, 0);
        add(RW, 1, 12'h342, 32'h8000_000B, 0, 0);
        add(RS, 0, 12'h342, 0, 32'h8000_000B, 0);
        add(RW, 1, 12'h343, 32'h0000_1234, 0, 0);
        add(RS, 0, 12'h343, 0, 32'h0000_1234, 0);
        add(RW, 1, 12'h341, 32'hFFFF_FFFF, 0, 0);
        add(RS, 0, 12'h341, 0, 32'hFFFF_FFFC, 0);

        foreach (tbl[i]) begin
            csr_valid = 1'b1; csr_op = tbl[i].op; csr_wr_en = tbl[i].we;
            csr_addr = tbl[i].addr; csr_wdata = tbl[i].wdata;
            #1;
            n_vec++;
            if (csr_rdata !== tbl[i].rdata || csr_illegal !== tbl[i].ill) begin
                n_bad++;
                $display("FAIL vec%0d addr %h: got rdata %h ill %b expected rdata %h ill %b",
                         i, tbl[i].addr, csr_rdata, csr_illegal, tbl[i].rdata, tbl[i].ill);
            end
            tick();
            csr_valid = 1'b0; csr_wr_en = 1'b0;
        end

        // ---------------- vectored timer interrupt ----------------
        wr(RW, 12'h305, 32'h8000_0001);
        wr(RW, 12'h304, 32'h0000_0080);
        wr(RW, 12'h300, 32'h0000_0008);
        mtip = 1'b1;
        #1 cmp("irq_pend_before_sample", {63'd0, irq_pending}, 64'd0);
        tick();
        cmp("irq_pend_after_sample", {63'd0, irq_pending}, 64'd1);
        irq_take = 1'b1; irq_pc = 32'h100;
        tick();
        irq_take = 1'b0;
        cmp("mti_redirect_valid", {63'd0, redirect_valid}, 64'd1);
        cmp("mti_redirect_pc", {32'd0, redirect_pc}, 64'h8000_001C);
        chk("mti_mcause", 12'h342, 32'h8000_0007);
        chk("mti_mepc", 12'h341, 32'h100);
        chk("mti_mstatus", 12'h300, 32'h1880);
        cmp("mti_pend_masked", {63'd0, irq_pending}, 64'd0);
        tick();
        cmp("mti_redirect_pulse_end", {63'd0, redirect_valid}, 64'd0);
        // irq_take with nothing pending is ignored
        irq_take = 1'b1; irq_pc = 32'h300;
        tick();
        irq_take = 1'b0;
        cmp("ignored_take_no_redirect", {63'd0, redirect_valid}, 64'd0);
        chk("ignored_take_mepc", 12'h341, 32'h100);

        // ---------------- exception beats mret and CSR write ----------------
        mtip = 1'b0;
        wr(RW, 12'h300, 32'h0000_0008);
        exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h200; exc_tval = 32'hDEAD;
        mret_valid = 1'b1;
        csr_valid = 1'b1; csr_op = RW; csr_wr_en = 1'b1; csr_addr = 12'h340; csr_wdata = 32'h77;
        tick();
        exc_valid = 1'b0; mret_valid = 1'b0; csr_valid = 1'b0; csr_wr_en = 1'b0;
        cmp("exc_redirect_valid", {63'd0, redirect_valid}, 64'd1);
        cmp("exc_redirect_pc", {32'd0, redirect_pc}, 64'h8000_0000);
        chk("exc_mcause", 12'h342, 32'h2);
        chk("exc_mtval", 12'h343, 32'hDEAD);
        chk("exc_mepc", 12'h341, 32'h200);
        chk("exc_mstatus", 12'h300, 32'h1880);
        chk("exc_mscratch_kept", 12'h340, 32'h00A5_FF0F);
        mret_valid = 1'b1;
        tick();
        mret_valid = 1'b0;
        cmp("mret_redirect_valid", {63'd0, redirect_valid}, 64'd1);
        cmp("mret_redirect_pc", {32'd0, redirect_pc}, 64'h200);
        chk("mret_mstatus", 12'h300, 32'h1888);
        wr(RW, 12'h341, 32'h203);
        chk("mepc_align", 12'h341, 32'h200);

        // ---------------- back-to-back exceptions ----------------
        exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h400; exc_tval = 32'h0;
        tick();
        cmp("b2b_first_redirect", {63'd0, redirect_valid}, 64'd1);
        chk("b2b_first_mcause", 12'h342, 32'h5);
        exc_cause = 5'd6; exc_pc = 32'h500;
        tick();
        exc_valid = 1'b0;
        cmp("b2b_second_redirect", {63'd0, redirect_valid}, 64'd1);
        cmp("b2b_second_pc", {32'd0, redirect_pc}, 64'h8000_0000);
        chk("b2b_mcause", 12'h342, 32'h6);
        chk("b2b_mepc", 12'h341, 32'h500);
        chk("b2b_mstatus", 12'h300, 32'h1800);
        tick();
        cmp("b2b_pulse_end", {63'd0, redirect_valid}, 64'd0);

        // ---------------- counters ----------------
        wr(RW, 12'hB80, 32'hFFFF_FFFF);
        wr(RW, 12'hB00, 32'hFFFF_FFFE);
        chk("mcycle_written", 12'hB00, 32'hFFFF_FFFE);
        chk("mcycleh_written", 12'hB80, 32'hFFFF_FFFF);
        tick();
        chk("mcycle_plus1", 12'hB00, 32'hFFFF_FFFF);
        tick();
        chk("mcycle_wrap_lo", 12'hB00, 32'h0);
        chk("mcycle_wrap_hi", 12'hB80, 32'h0);
        instret = 1'b1;
        wr(RW, 12'hB02, 32'h10);
        chk("minstret_write_wins", 12'hB02, 32'h10);
        tick(); tick();
        instret = 1'b0;
        chk("minstret_count", 12'hB02, 32'h12);
        tick();
        chk("minstret_hold", 12'hB02, 32'h12);

        // ---------------- interrupt priority ----------------
        wr(RW, 12'h305, 32'h0000_1000);
        wr(RW, 12'h304, 32'h0008_0888);
        meip = 1'b1; msip = 1'b1; lcl_irq = 16'h0008;
        wr(RW, 12'h300, 32'h8);
        cmp("prio_pend1", {63'd0, irq_pending}, 64'd1);
        irq_take = 1'b1; irq_pc = 32'h600;
        tick();
        irq_take = 1'b0;
        chk("prio_mei", 12'h342, 32'h8000_000B);
        cmp("prio_direct_pc", {32'd0, redirect_pc}, 64'h1000);
        meip = 1'b0;
        wr(RW, 12'h300, 32'h8);
        cmp("prio_pend2", {63'd0, irq_pending}, 64'd1);
        irq_take = 1'b1;
        tick();
        irq_take = 1'b0;
        chk("prio_msi", 12'h342, 32'h8000_0003);
        msip = 1'b0;
        wr(RW, 12'h300, 32'h8);
        cmp("prio_pend3", {63'd0, irq_pending}, 64'd1);
        irq_take = 1'b1;
        tick();
        irq_take = 1'b0;
        chk("prio_lcl3", 12'h342, 32'h8000_0013);
        lcl_irq = '0;

        // ---------------- async reset during redirect ----------------
        exc_valid = 1'b1; exc_cause = 5'd1; exc_pc = 32'h700;
        tick();
        exc_valid = 1'b0;
        cmp("pre_rst_redirect", {63'd0, redirect_valid}, 64'd1);
        rst = 1'b1;
        #1;
        cmp("rst_async_redirect_valid", {63'd0, redirect_valid}, 64'd0);
        cmp("rst_async_redirect_pc", {32'd0, redirect_pc}, 64'd0);
        chk("rst_async_mstatus", 12'h300, 32'h1800);
        chk("rst_async_mscratch", 12'h340, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
